tdm_demux: RTL and testbench

//  Time-division demultiplexer: receiving end of a round-robin TDM mux link.

---
 rtl/tdm_demux.sv | 129 ++++++++++++
 tb/tb_tdm_demux.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receiving end of a round-robin TDM link.
// Collects LANES consecutive valid samples (slot 0 flagged by frame_sync)
// into a staging register and publishes each complete frame on dout with
// a one-cycle dout_valid strobe. Tracks slot alignment and drops back to
// hunting for frame_sync whenever a sample arrives in slot 0 without it.
module tdm_demux #(
  parameter int LANES = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       frame_sync,
  output logic [LANES*WIDTH-1:0]     dout,
  output logic                       dout_valid,
  output logic                       locked,
  output logic                       sync_err,
  output logic [$clog2(LANES)-1:0]   slot
);

  localparam int SLOT_W = $clog2(LANES);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LANES - 1);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                      state, state_nxt;
  logic [SLOT_W-1:0]           slot_cnt, slot_nxt;
  logic [SLOT_W-1:0]           wr_idx;
  logic                        stage_we;
  logic                        frame_done;
  logic                        err_nxt;

  // Lanes 0..LANES-2 wait here; the last lane goes straight into dout.
  logic [(LANES-1)*WIDTH-1:0]  staging;

  // State and slot counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HUNT;
      slot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_nxt;
    end
  end

  // Next-state decode: alignment checks, staging writes and frame completion.
  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot_cnt;
    wr_idx     = slot_cnt;
    stage_we   = 1'b0;
    frame_done = 1'b0;
    err_nxt    = 1'b0;
    if (din_valid) begin
      unique case (state)
        ST_HUNT: begin
          // Only a flagged slot-0 sample can start a frame; others vanish silently.
          if (frame_sync) begin
            wr_idx    = '0;
            stage_we  = 1'b1;
            slot_nxt  = SLOT_W'(1);
            state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (frame_sync) begin
            // A sync mid-frame restarts the frame; the partial one is abandoned.
            err_nxt  = (slot_cnt != '0);
            wr_idx   = '0;
            stage_we = 1'b1;
            slot_nxt = SLOT_W'(1);
          end else if (slot_cnt == '0) begin
            // Slot 0 without sync means alignment is lost.
            err_nxt   = 1'b1;
            slot_nxt  = '0;
            state_nxt = ST_HUNT;
          end else if (slot_cnt == LAST_SLOT) begin
            frame_done = 1'b1;
            slot_nxt   = '0;
          end else begin
            stage_we = 1'b1;
            slot_nxt = slot_cnt + SLOT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_HUNT;
          slot_nxt  = '0;
        end
      endcase
    end
  end

  // Staging lanes: written one sample at a time as the frame arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging <= '0;
    end else if (stage_we) begin
      for (int i = 0; i < LANES - 1; i++) begin
        if (wr_idx == SLOT_W'(i)) begin
          staging[i*WIDTH +: WIDTH] <= din;
        end
      end
    end
  end

  // Output frame register and status strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= frame_done;
      sync_err   <= err_nxt;
      if (frame_done) begin
        dout <= {din, staging};
      end
    end
  end

  assign locked = (state == ST_LOCKED);
  assign slot   = slot_cnt;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with LANES=4, WIDTH=4.
module tb_tdm_demux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  din;
  logic        din_valid;
  logic        frame_sync;
  logic [15:0] dout;
  logic        dout_valid;
  logic        locked;
  logic        sync_err;
  logic [1:0]  slot;

  int n_checks = 0;
  int n_pass   = 0;

  tdm_demux #(.LANES(4), .WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err),
    .slot       (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one valid sample across one rising edge, then check the strobes.
  task automatic send(input logic [3:0] d, input logic sync,
                      input logic exp_dv, input logic exp_err, input logic [1:0] exp_slot);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = sync;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    check("dout_valid", dout_valid, exp_dv);
    check("sync_err", sync_err, exp_err);
    check("slot", slot, exp_slot);
  endtask

  // Idle cycles: no strobes may appear and dout must hold.
  task automatic idle(input int n, input logic [15:0] exp_dout);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      check("idle dout_valid", dout_valid, 1'b0);
      check("idle sync_err", sync_err, 1'b0);
      check("idle dout", dout, exp_dout);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    #1;
    check("rst dout", dout, 16'h0);
    check("rst dout_valid", dout_valid, 1'b0);
    check("rst locked", locked, 1'b0);
    check("rst sync_err", sync_err, 1'b0);
    check("rst slot", slot, 2'd0);
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 1,2,3,4
    send(4'h1, 1'b1, 1'b0, 1'b0, 2'd1);
    check("locked after sync", locked, 1'b1);
    send(4'h2, 1'b0, 1'b0, 1'b0, 2'd2);
    send(4'h3, 1'b0, 1'b0, 1'b0, 2'd3);
    send(4'h4, 1'b0, 1'b1, 1'b0, 2'd0);
    check("frame1 dout", dout, 16'h4321);
    check("frame1 locked", locked, 1'b1);
    idle(1, 16'h4321);

    // Same frame with gaps, then back-to-back frames
    send(4'h1, 1'b1, 1'b0, 1'b0, 2'd1);
    send(4'h2, 1'b0, 1'b0, 1'b0, 2'd2);
    idle(1, 16'h4321);
    send(4'h3, 1'b0, 1'b0, 1'b0, 2'd3);
    idle(3, 16'h4321);
    send(4'h4, 1'b0, 1'b1, 1'b0, 2'd0);
    check("gap frame dout", dout, 16'h4321);
    send(4'h5, 1'b1, 1'b0, 1'b0, 2'd1);
    send(4'h6, 1'b0, 1'b0, 1'b0, 2'd2);
    send(4'h7, 1'b0, 1'b0, 1'b0, 2'd3);
    send(4'h8, 1'b0, 1'b1, 1'b0, 2'd0);
    check("b2b frame A dout", dout, 16'h8765);
    send(4'h9, 1'b1, 1'b0, 1'b0, 2'd1);
    check("dout holds", dout, 16'h8765);
    send(4'hA, 1'b0, 1'b0, 1'b0, 2'd2);
    send(4'hB, 1'b0, 1'b0, 1'b0, 2'd3);
    send(4'hC, 1'b0, 1'b1, 1'b0, 2'd0);
    check("b2b frame B dout", dout, 16'hCBA9);
    idle(1, 16'hCBA9);

    // Early sync: A,B abandoned, C restarts the frame
    send(4'hA, 1'b1, 1'b0, 1'b0, 2'd1);
    send(4'hB, 1'b0, 1'b0, 1'b0, 2'd2);
    send(4'hC, 1'b1, 1'b0, 1'b1, 2'd1);
    check("early sync locked", locked, 1'b1);
    send(4'hD, 1'b0, 1'b0, 1'b0, 2'd2);
    send(4'hE, 1'b0, 1'b0, 1'b0, 2'd3);
    send(4'hF, 1'b0, 1'b1, 1'b0, 2'd0);
    check("early sync dout", dout, 16'hFEDC);
    idle(1, 16'hFEDC);

    // Missing sync at slot 0: back to hunting
    send(4'h7, 1'b0, 1'b0, 1'b1, 2'd0);
    check("missing sync locked", locked, 1'b0);
    send(4'h1, 1'b0, 1'b0, 1'b0, 2'd0);
    send(4'h2, 1'b0, 1'b0, 1'b0, 2'd0);
    check("hunt ignores locked", locked, 1'b0);
    send(4'h1, 1'b1, 1'b0, 1'b0, 2'd1);
    check("relock", locked, 1'b1);
    send(4'h2, 1'b0, 1'b0, 1'b0, 2'd2);
    send(4'h3, 1'b0, 1'b0, 1'b0, 2'd3);
    send(4'h4, 1'b0, 1'b1, 1'b0, 2'd0);
    check("relock dout", dout, 16'h4321);

    // Reset mid-frame, asynchronous
    send(4'h5, 1'b1, 1'b0, 1'b0, 2'd1);
    send(4'h6, 1'b0, 1'b0, 1'b0, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst dout", dout, 16'h0);
    check("async rst dout_valid", dout_valid, 1'b0);
    check("async rst locked", locked, 1'b0);
    check("async rst sync_err", sync_err, 1'b0);
    check("async rst slot", slot, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'h7, 1'b0, 1'b0, 1'b0, 2'd0);
    check("post rst locked", locked, 1'b0);
    send(4'h8, 1'b0, 1'b0, 1'b0, 2'd0);
    check("post rst locked 2", locked, 1'b0);
    check("post rst dout", dout, 16'h0);

    // Recovery after reset
    send(4'h5, 1'b1, 1'b0, 1'b0, 2'd1);
    send(4'h6, 1'b0, 1'b0, 1'b0, 2'd2);
    send(4'h7, 1'b0, 1'b0, 1'b0, 2'd3);
    send(4'h8, 1'b0, 1'b1, 1'b0, 2'd0);
    check("post rst frame dout", dout, 16'h8765);
    idle(1, 16'h8765);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
